uart_status_arb: RTL

UART_STATUS_ARB -- requirements
Module: uart_status_arb

---
 rtl/uart_status_arb.sv | 130 +++++++++++++
 1 files changed

// File: rtl/uart_status_arb.sv
// uart_status_arb: two-requester read-on-clear arbiter for a UART status register.
// Sequence: IDLE -> SAMPLE (capture status) -> CLEAR (one-cycle re + mask) -> RESP.
// A zero mask skips CLEAR, so no status_re pulse is issued for that read.
// Optional feature: define UART_STATUS_ARB_RR_EN for round-robin tie-breaking.
// Without it, req0 always wins a tie.
module uart_status_arb #(
  parameter int DW = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic [DW-1:0] mask0,
  input  logic [DW-1:0] mask1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata,
  output logic          status_re,
  output logic [DW-1:0] status_rmask,
  input  logic [DW-1:0] status_data
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SAMPLE = 2'd1,
    CLEAR  = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t        state_reg;
  logic [DW-1:0] mask_reg;    // clear mask latched at grant time
  logic          sel_reg;     // index of the granted requester
  logic          pick1;       // winner of the current IDLE evaluation is requester 1
  logic          any_req;

  assign any_req = req0 | req1;

`ifdef UART_STATUS_ARB_RR_EN
  logic ptr_reg;              // last granted requester; a tie goes to the other one

  // Tie-break: requester 1 wins a tie only when requester 0 was granted last.
  always_comb begin
    pick1 = req1 & (~req0 | ~ptr_reg);
  end

  // Record the most recent grant; reset value makes req0 win the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_reg <= 1'b1;
    end else if (state_reg == IDLE && any_req) begin
      ptr_reg <= pick1;
    end
  end
`else
  // Fixed priority: requester 0 always wins.
  always_comb begin
    pick1 = req1 & ~req0;
  end
`endif

  // Main sequencer with all outputs registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      mask_reg     <= '0;
      sel_reg      <= 1'b0;
      gnt0         <= 1'b0;
      gnt1         <= 1'b0;
      rvalid0      <= 1'b0;
      rvalid1      <= 1'b0;
      rdata        <= '0;
      status_re    <= 1'b0;
      status_rmask <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (any_req) begin
            sel_reg   <= pick1;
            mask_reg  <= pick1 ? mask1 : mask0;
            gnt0      <= ~pick1;
            gnt1      <= pick1;
            state_reg <= SAMPLE;
          end
        end
        SAMPLE: begin
          // Capture before the clear; the register zeroes masked bits while re is high.
          rdata <= status_data;
          if (mask_reg == '0) begin
            rvalid0   <= ~sel_reg;
            rvalid1   <= sel_reg;
            state_reg <= RESP;
          end else begin
            status_re    <= 1'b1;
            status_rmask <= mask_reg;
            state_reg    <= CLEAR;
          end
        end
        CLEAR: begin
          status_re    <= 1'b0;
          status_rmask <= '0;
          rvalid0      <= ~sel_reg;
          rvalid1      <= sel_reg;
          state_reg    <= RESP;
        end
        RESP: begin
          rvalid0   <= 1'b0;
          rvalid1   <= 1'b0;
          gnt0      <= 1'b0;
          gnt1      <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

`ifndef SYNTHESIS
  // Grants are one-hot at most.
  a_gnt_onehot: assert property (@(posedge clk) disable iff (rst) !(gnt0 && gnt1));
  // The read-enable only ever appears while in CLEAR.
  a_re_in_clear: assert property (@(posedge clk) disable iff (rst) status_re |-> (state_reg == CLEAR));
  // The clear mask is idle-zero whenever no read-enable is issued.
  a_rmask_idle: assert property (@(posedge clk) disable iff (rst) !status_re |-> (status_rmask == '0));
`endif

endmodule
